uart_tx: RTL and testbench

UART transmitter: serializes one byte per valid/ready handshake into an 8N1 frame on `tx` (start bit, 8 data bits LSB first, one stop bit) at `BAUD_RATE`. It is the transmit half of the serial link, paired with `uart_rx` on the same `clk` domain, and shares its clock/baud parameters. A one-cycle `tx_done` pulse marks completion of each frame.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 107 ++++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: clock/baud defaults,
// frame width and the common state encoding.
package uart_pkg;

  localparam int DEFAULT_CLOCK_FREQ = 50000000;
  localparam int DEFAULT_BAUD_RATE  = 9600;
  localparam int DATA_BITS          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake plus serial line and status for the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while clear is high so a new bit starts aligned.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts
// it out LSB first between a low start bit and a high stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic [1:0]           r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_clear;

  // The bit counter is parked at zero while idle, so the start bit gets a full
  // CLKS_PER_BIT cycles measured from the acceptance edge.
  assign w_clear = (r_state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (bus.tx_valid) begin
            r_shift <= bus.tx_data;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        // The shift register always presents the current bit at [0], so the
        // next bit to drive is [1] just before the shift takes effect.
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_idx == LAST_IDX) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_tx  <= r_shift[1];
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready = (r_state == ST_IDLE);
  assign bus.tx       = r_tx;
  assign bus.tx_busy  = r_busy;
  assign bus.tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model checks every output each
// cycle, literal waveforms pin directed cases, and a bench receiver loops back.
module tb_uart_tx;

  localparam int N = 16;

  logic clk;
  logic rst;

  uart_tx_if bus ();

  uart_tx #(
    .CLOCK_FREQ(1600),
    .BAUD_RATE (100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame-level model state: when the current frame began and its 10 bits.
  bit         modelLive = 1'b0;
  int         mFrameStart = -1;
  logic [9:0] mFrame = '1;
  bit         mDoneNow = 1'b0;
  int         lastAccept = -1;

  bit         rxEnable = 1'b0;
  logic [7:0] sentQ[$];

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %b expected %b at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // The model sees the same sampled inputs as the DUT on each rising edge.
  always @(posedge clk) begin
    cyc++;
    mDoneNow = 1'b0;
    if (rst) begin
      modelLive   = 1'b1;
      mFrameStart = -1;
    end else if (modelLive) begin
      if (mFrameStart >= 0 && cyc == mFrameStart + 10 * N) begin
        mFrameStart = -1;
        mDoneNow    = 1'b1;
      end else if (mFrameStart < 0 && bus.tx_valid) begin
        mFrameStart = cyc;
        mFrame      = {1'b1, bus.tx_data, 1'b0};
        lastAccept  = cyc;
        if (rxEnable) sentQ.push_back(bus.tx_data);
      end
    end
  end

  always @(negedge clk) begin
    logic eTx, eBusy, eReady, eDone;
    if (modelLive) begin
      if (mFrameStart >= 0) begin
        eTx    = mFrame[(cyc - mFrameStart) / N];
        eBusy  = 1'b1;
        eReady = 1'b0;
        eDone  = 1'b0;
      end else begin
        eTx    = 1'b1;
        eBusy  = 1'b0;
        eReady = 1'b1;
        eDone  = mDoneNow;
      end
      checkOutput("model_tx", bus.tx, eTx);
      checkOutput("model_busy", bus.tx_busy, eBusy);
      checkOutput("model_ready", bus.tx_ready, eReady);
      checkOutput("model_done", bus.tx_done, eDone);
    end
  end

  // Loopback receiver: finds the start edge and samples each bit mid-period.
  bit         rxPrev = 1'b1;
  bit         rxActive = 1'b0;
  int         rxStart = 0;
  logic [7:0] rxByte = '0;
  int         rxCount = 0;

  always @(negedge clk) begin
    int off, k;
    if (rxEnable) begin
      if (!rxActive) begin
        if (rxPrev && !bus.tx) begin
          rxActive = 1'b1;
          rxStart  = cyc;
        end
      end else begin
        off = cyc - rxStart;
        if (off >= N / 2 && (off - N / 2) % N == 0) begin
          k = (off - N / 2) / N;
          if (k == 0) begin
            checkOutput("rx_start_bit", bus.tx, 1'b0);
          end else if (k <= 8) begin
            rxByte[k-1] = bus.tx;
          end else begin
            checkOutput("rx_stop_bit", bus.tx, 1'b1);
            rxActive = 1'b0;
            rxCount++;
            if (sentQ.size() == 0) begin
              checkInt("rx_unexpected_byte", int'(rxByte), -1);
            end else begin
              checkInt("rx_byte", int'(rxByte), int'(sentQ.pop_front()));
            end
          end
        end
      end
    end
    rxPrev = bus.tx;
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Presents a byte and waits for the handshake; t is the acceptance edge.
  task automatic applyStimulus(input logic [7:0] d, input bit keep, output int t);
    int guard;
    guard = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    do begin
      stepEdge();
      guard++;
    end while (lastAccept != cyc && guard < 400);
    if (lastAccept != cyc) checkInt("accept_timeout", guard, -1);
    t = cyc;
    if (!keep) bus.tx_valid = 1'b0;
  endtask

  task automatic checkFrameBits(input int t, input logic [9:0] pattern, input string tag);
    for (int k = 0; k < 10; k++) begin
      waitUntil(t + N / 2 + k * N);
      checkOutput(tag, bus.tx, pattern[k]);
    end
  endtask

  initial begin
    int t, t1, tPulse, gap;
    logic [7:0] d;

    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (200) stepEdge();
    waitUntil(cyc + 1);
    checkOutput("idle_tx", bus.tx, 1'b1);
    checkOutput("idle_ready", bus.tx_ready, 1'b1);
    stepEdge();

    $display("[TB] frame 0xA5 with ignored mid-frame valid");
    applyStimulus(8'hA5, 1'b0, t);
    tPulse = t;
    fork
      begin
        do stepEdge(); while (cyc < tPulse + 49);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h3C;
        stepEdge();
        bus.tx_valid = 1'b0;
      end
    join_none
    checkFrameBits(t, 10'b11_0100_1010, "a5_bit");
    waitUntil(t + 159);
    checkOutput("a5_done_early", bus.tx_done, 1'b0);
    waitUntil(t + 160);
    checkOutput("a5_done", bus.tx_done, 1'b1);
    checkOutput("a5_ready_end", bus.tx_ready, 1'b1);

    $display("[TB] back-to-back 0x00 then 0xFF");
    stepEdge();
    applyStimulus(8'h00, 1'b1, t1);
    bus.tx_data = 8'hFF;
    checkFrameBits(t1, 10'b10_0000_0000, "b2b_first_bit");
    waitUntil(t1 + 160);
    checkOutput("b2b_done1", bus.tx_done, 1'b1);
    waitUntil(t1 + 161);
    checkOutput("b2b_second_start", bus.tx, 1'b0);
    checkOutput("b2b_second_busy", bus.tx_busy, 1'b1);
    bus.tx_valid = 1'b0;
    checkFrameBits(t1 + 161, 10'b11_1111_1110, "b2b_second_bit");
    waitUntil(t1 + 321);
    checkOutput("b2b_done2", bus.tx_done, 1'b1);

    $display("[TB] reset mid-frame then 0x81");
    stepEdge();
    applyStimulus(8'h5A, 1'b0, t);
    do stepEdge(); while (cyc < t + 69);
    rst = 1'b1;
    stepEdge();
    rst = 1'b0;
    waitUntil(t + 70);
    checkOutput("rst_tx", bus.tx, 1'b1);
    checkOutput("rst_busy", bus.tx_busy, 1'b0);
    checkOutput("rst_ready", bus.tx_ready, 1'b1);
    repeat (200) stepEdge();
    applyStimulus(8'h81, 1'b0, t);
    checkFrameBits(t, 10'b11_0000_0010, "x81_bit");
    waitUntil(t + 160);
    checkOutput("x81_done", bus.tx_done, 1'b1);

    $display("[TB] random loopback");
    stepEdge();
    rxEnable = 1'b1;
    for (int i = 0; i < 256; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) stepEdge();
      d = 8'($urandom);
      applyStimulus(d, 1'b0, t);
      if ($urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, 140);
        repeat (gap) stepEdge();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'($urandom);
        stepEdge();
        bus.tx_valid = 1'b0;
      end
    end
    repeat (10 * N + 20) stepEdge();
    checkInt("rx_count", rxCount, 256);
    checkInt("rx_queue_empty", sentQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
